// File: rtl/aemb_bsft_pkg.sv
// Shared mode encodings and helpers for the pipelined AEMB barrel shifter.
// Imported by the interface, the stage and the top.
package aemb_bsft_pkg;

  typedef logic [1:0] bsf_mode_t;

  localparam bsf_mode_t BSF_SRL = 2'd0;
  localparam bsf_mode_t BSF_SRA = 2'd1;
  localparam bsf_mode_t BSF_SLL = 2'd2;
  localparam bsf_mode_t BSF_ROL = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/aemb_bsft_if.sv
// Valid/ready link between shifter stages: partial data, mode,
// amount, carried sign bit and tag.
interface aemb_bsft_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int TW = 5
);
  import aemb_bsft_pkg::*;

  logic          vld;
  logic          rdy;
  logic [DW-1:0] dat;
  logic [AW-1:0] amt;
  bsf_mode_t     mode;
  logic          msb;
  logic [TW-1:0] tag;

  modport master (
    output vld, dat, amt, mode, msb, tag,
    input  rdy
  );

  modport slave (
    input  vld, dat, amt, mode, msb, tag,
    output rdy
  );

endinterface

// File: rtl/aemb_bsft_stage.sv
// One pipeline stage: applies shift levels LO..HI, then registers
// the result behind a valid/ready slot that collapses bubbles.
module aemb_bsft_stage
  import aemb_bsft_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int TW = 5,
  parameter int LO = 0,
  parameter int HI = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  aemb_bsft_if.slave    up,
  aemb_bsft_if.master   dn
);

  logic          vld_q;
  logic          rdy;
  logic [DW-1:0] dat_q;
  logic [DW-1:0] nxt;
  logic [AW-1:0] amt_q;
  bsf_mode_t     mode_q;
  logic          msb_q;
  logic [TW-1:0] tag_q;

  always_comb begin
    nxt = up.dat;
    for (int i = LO; i <= HI; i++) begin
      if (up.amt[i]) begin
        unique case (up.mode)
          BSF_SRL: nxt = nxt >> (2 ** i);
          BSF_SRA: nxt = (nxt >> (2 ** i))
                       | ({DW{up.msb}}
                          & ~({DW{1'b1}} >> (2 ** i)));
          BSF_SLL: nxt = nxt << (2 ** i);
          BSF_ROL: nxt = (nxt << (2 ** i))
                       | (nxt >> (DW - 2 ** i));
        endcase
      end
    end
  end

  // flush forces acceptance so a same-cycle offer is swallowed
  assign rdy    = !vld_q || dn.rdy || flush;
  assign up.rdy = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      amt_q  <= '0;
      mode_q <= BSF_SRL;
      msb_q  <= 1'b0;
      tag_q  <= '0;
    end else begin
      if (flush)    vld_q <= 1'b0;
      else if (rdy) vld_q <= up.vld;
      if (up.vld && rdy) begin
        dat_q  <= nxt;
        amt_q  <= up.amt;
        mode_q <= up.mode;
        msb_q  <= up.msb;
        tag_q  <= up.tag;
      end
    end
  end

  assign dn.vld  = vld_q;
  assign dn.dat  = dat_q;
  assign dn.amt  = amt_q;
  assign dn.mode = mode_q;
  assign dn.msb  = msb_q;
  assign dn.tag  = tag_q;

endmodule

// File: rtl/aemb_bsft.sv
// Pipelined barrel shifter top: SRL/SRA/SLL/ROL spread over NSTG
// valid/ready stages with a tag carried alongside the data.
module aemb_bsft_pipe
  import aemb_bsft_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NSTG = 2,
  parameter int TW   = 5
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          flush,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_opa,
  input  logic [AW-1:0] in_amt,
  input  logic [1:0]    in_mode,
  input  logic [TW-1:0] in_tag,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_res,
  output logic [TW-1:0] out_tag
);

  if (DW < 8 || DW > 64 || (DW & (DW - 1)) != 0) begin : g_bad_dw
    $error("aemb_bsft_pipe: DW must be a power of two in 8..64");
  end
  if (AW != clog2(DW)) begin : g_bad_aw
    $error("aemb_bsft_pipe: AW must equal clog2(DW)");
  end
  if (NSTG < 1 || NSTG > AW) begin : g_bad_nstg
    $error("aemb_bsft_pipe: NSTG must lie in 1..AW");
  end

  aemb_bsft_if #(.DW(DW), .AW(AW), .TW(TW)) lnk [0:NSTG] ();

  assign lnk[0].vld  = in_vld;
  assign lnk[0].dat  = in_opa;
  assign lnk[0].amt  = in_amt;
  assign lnk[0].mode = in_mode;
  assign lnk[0].msb  = in_opa[DW-1];
  assign lnk[0].tag  = in_tag;
  assign in_rdy      = lnk[0].rdy;

  // level i runs in stage floor(i*NSTG/AW)
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    aemb_bsft_stage #(
      .DW(DW),
      .AW(AW),
      .TW(TW),
      .LO((k * AW + NSTG - 1) / NSTG),
      .HI(((k + 1) * AW + NSTG - 1) / NSTG - 1)
    ) u_stage (
      .clk  (gclk),
      .rst_n(grst_n),
      .flush(flush),
      .up   (lnk[k]),
      .dn   (lnk[k+1])
    );
  end

  assign lnk[NSTG].rdy = out_rdy;
  assign out_vld       = lnk[NSTG].vld;
  assign out_res       = lnk[NSTG].dat;
  assign out_tag       = lnk[NSTG].tag;

  logic unused_tail;
  assign unused_tail = ^{lnk[NSTG].amt, lnk[NSTG].mode,
                         lnk[NSTG].msb};

endmodule
